// File: rtl/cpu_core_if.sv
// Memory bus between cpu_core and its synchronous byte-wide RAM.
// The write-data signal is dout because "do" is a reserved word.
interface cpu_core_if;
  logic [15:0] addr;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        we;

  modport master (output addr, output dout, output we, input di);
  modport slave  (input addr, input dout, input we, output di);
endinterface

// File: rtl/cpu_core.sv
// 8-bit register CPU: fixed 3-byte instructions, eight registers, Z/C flags.
// Optional macro CPU_CARRY_EN adds the C flag (ADC carry-in, JC branching).
module cpu_core (
  input  logic       clk,
  input  logic       rst,
  cpu_core_if.master mem
);

  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_ST   = 5'd3;
  localparam logic [4:0] OP_MOV  = 5'd4;
  localparam logic [4:0] OP_ADD  = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_ADC  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [4:0] OP_JZ   = 5'd12;
  localparam logic [4:0] OP_JNZ  = 5'd13;
  localparam logic [4:0] OP_JC   = 5'd14;
  localparam logic [4:0] OP_HALT = 5'd15;

  typedef enum logic [2:0] {F0, F1, F2, F3, EX, MW, H} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg;
  logic [7:0]  b0_reg, b1_reg, b2_reg;
  logic [7:0]  regs [8];
  logic        z_reg;
  logic        carry_in;

  logic [4:0]  opcode;
  logic [2:0]  rd_idx, rs_idx;
  logic [15:0] target;
  logic [7:0]  rd_val, rs_val;

  logic        wr_en, z_upd, taken;
  logic [7:0]  wr_data;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_sel;

  assign opcode = b0_reg[7:3];
  assign rd_idx = b0_reg[2:0];
  assign rs_idx = b1_reg[2:0];
  assign target = {b1_reg, b2_reg};
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];

  // Execute-stage datapath: result, flag updates and branch decision.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = rd_val;
    z_upd   = 1'b0;
    taken   = 1'b0;
    case (opcode)
      OP_LDI: begin wr_en = 1'b1; wr_data = b1_reg; end
      OP_MOV: begin wr_en = 1'b1; wr_data = rs_val; end
      OP_ADD: begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val + rs_val; end
      OP_ADC: begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val + rs_val + {7'd0, carry_in}; end
      OP_SUB: begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val - rs_val; end
      OP_AND: begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val & rs_val; end
      OP_OR:  begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val | rs_val; end
      OP_XOR: begin wr_en = 1'b1; z_upd = 1'b1; wr_data = rd_val ^ rs_val; end
      OP_JMP: taken = 1'b1;
      OP_JZ:  taken = z_reg;
      OP_JNZ: taken = ~z_reg;
      OP_JC:  taken = carry_in;
      default: ;
    endcase
  end

`ifdef CPU_CARRY_EN
  logic       c_reg;
  logic       c_upd, c_next;
  logic [8:0] carry_sum;

  assign carry_in  = c_reg;
  assign carry_sum = {1'b0, rd_val} + {1'b0, rs_val} + {8'd0, (opcode == OP_ADC) ? c_reg : 1'b0};

  always_comb begin
    c_upd  = 1'b0;
    c_next = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC:        begin c_upd = 1'b1; c_next = carry_sum[8]; end
      OP_SUB:                begin c_upd = 1'b1; c_next = (rd_val < rs_val); end
      OP_AND, OP_OR, OP_XOR: begin c_upd = 1'b1; c_next = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      c_reg <= 1'b0;
    else if (state_reg == EX && c_upd)
      c_reg <= c_next;
  end
`else
  assign carry_in = 1'b0;
`endif

  // Write-back happens on the edge leaving EX (ALU/LDI/MOV) or MW (LD).
  assign reg_we    = (state_reg == EX && wr_en) || (state_reg == MW);
  assign reg_wdata = (state_reg == MW) ? mem.di : wr_data;

  for (genvar gi = 0; gi < 8; gi++) begin : g_reg_sel
    assign reg_sel[gi] = reg_we && (rd_idx == 3'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst)
        regs[i] <= '0;
      else if (reg_sel[i])
        regs[i] <= reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= '0;
      b0_reg <= '0;
      b1_reg <= '0;
      b2_reg <= '0;
      z_reg  <= 1'b0;
    end else begin
      case (state_reg)
        F1: b0_reg <= mem.di;
        F2: b1_reg <= mem.di;
        F3: b2_reg <= mem.di;
        EX: begin
          if (opcode != OP_HALT)
            pc_reg <= taken ? target : pc_reg + 16'd3;
          if (z_upd)
            z_reg <= (wr_data == 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= F0;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = F0;
    case (state_reg)
      F0: state_next = F1;
      F1: state_next = F2;
      F2: state_next = F3;
      F3: state_next = EX;
      EX: begin
        if (opcode == OP_HALT)
          state_next = H;
        else if (opcode == OP_LD)
          state_next = MW;
        else
          state_next = F0;
      end
      MW: state_next = F0;
      H:  state_next = H;
      default: state_next = F0;
    endcase
  end

  // Store write is gated by rst so a reset on the ST-EX edge never commits.
  always_comb begin
    mem.addr = pc_reg;
    mem.dout = '0;
    mem.we   = 1'b0;
    case (state_reg)
      F1:     mem.addr = pc_reg + 16'd1;
      F2, F3: mem.addr = pc_reg + 16'd2;
      EX: begin
        if (opcode == OP_LD || opcode == OP_ST)
          mem.addr = target;
        if (opcode == OP_ST) begin
          mem.dout = rd_val;
          mem.we   = ~rst;
        end
      end
      MW:     mem.addr = target;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: loads small programs into a RAM model and
// scoreboards every memory write against expected (addr, data) pairs.
module tb_cpu_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_core_if bus ();
  cpu_core dut (.clk(clk), .rst(rst), .mem(bus));

  logic [7:0]  mem [0:65535];
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  always @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
    else if (bus.we)
      mem[bus.addr] <= bus.dout;
    bus.di <= mem[bus.addr];
  end

  int          tests_run = 0;
  int          failures  = 0;
  logic [23:0] exp_q [$];
  logic [15:0] trace [0:1023];
  int          we_count;
  int          we_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
  endtask

  task automatic instr(input logic [15:0] a, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    load_byte(a, x0);
    load_byte(a + 16'd1, x1);
    load_byte(a + 16'd2, x2);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Releases reset, runs ncycles (cycle 0 = first F0), optionally pulses rst
  // during cycle rst_cycle, and leaves the core held in reset afterwards.
  task automatic run(input int ncycles, input int rst_cycle);
    logic [23:0] item;
    we_count = 0;
    we_last  = -1;
    for (int k = 0; k < ncycles; k++) begin
      @(negedge clk);
      load_en = 1'b0;
      rst     = (k == rst_cycle);
      #1;
      trace[k] = bus.addr;
      if (k == 0 || k == rst_cycle + 1) begin
        check("reset_addr", bus.addr, 0);
        check("reset_we", bus.we, 0);
        check("reset_dout", bus.dout, 0);
      end
      if (bus.we) begin
        we_count++;
        we_last = k;
        $display("[TB] cycle %0d write addr=%h data=%h", k, bus.addr, bus.dout);
        check("sb_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          item = exp_q.pop_front();
          check("wr_addr", bus.addr, item[23:8]);
          check("wr_data", bus.dout, item[7:0]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (2) @(negedge clk);

    // LDI r1,5; ST r1,[0x0064]; HALT
    instr(16'h0000, 8'h09, 8'h05, 8'h00);
    instr(16'h0003, 8'h19, 8'h00, 8'h64);
    instr(16'h0006, 8'h78, 8'h00, 8'h00);
    expect_wr(16'h0064, 8'h05);
    run(40, -1);
    check("p1_we_count", we_count, 1);
    check("p1_we_cycle", we_last, 9);
    check("p1_mem100", mem[100], 8'h05);
    bad = 0;
    for (int k = 15; k < 40; k++)
      if (trace[k] !== 16'h0006) bad++;
    check("p1_halt_addr_const", bad, 0);

    // Same program, reset on the ST-EX edge: the write must not land.
    load_byte(16'h0064, 8'hAB);
    run(10, 9);
    check("st_rst_we_count", we_count, 0);
    check("st_rst_mem100", mem[100], 8'hAB);

    // ADD/ADC carry behaviour, observed via stores and JC.
    instr(16'h0000, 8'h09, 8'd200, 8'h00);
    instr(16'h0003, 8'h0A, 8'd100, 8'h00);
    instr(16'h0006, 8'h29, 8'h02, 8'h00);
    instr(16'h0009, 8'h19, 8'h00, 8'h64);
    instr(16'h000C, 8'h70, 8'h00, 8'h30);
    instr(16'h000F, 8'h0D, 8'hEE, 8'h00);
    instr(16'h0012, 8'h1D, 8'h00, 8'h65);
    instr(16'h0015, 8'h58, 8'h00, 8'h36);
    instr(16'h0030, 8'h0D, 8'hCC, 8'h00);
    instr(16'h0033, 8'h1D, 8'h00, 8'h65);
    instr(16'h0036, 8'h51, 8'h02, 8'h00);
    instr(16'h0039, 8'h19, 8'h00, 8'h64);
    instr(16'h003C, 8'h70, 8'h00, 8'h50);
    instr(16'h003F, 8'h0E, 8'h11, 8'h00);
    instr(16'h0042, 8'h1E, 8'h00, 8'h66);
    instr(16'h0045, 8'h78, 8'h00, 8'h00);
    instr(16'h0050, 8'h0E, 8'h22, 8'h00);
    instr(16'h0053, 8'h1E, 8'h00, 8'h66);
    instr(16'h0056, 8'h78, 8'h00, 8'h00);
    expect_wr(16'h0064, 8'd44);
`ifdef CPU_CARRY_EN
    expect_wr(16'h0065, 8'hCC);
    expect_wr(16'h0064, 8'd145);
`else
    expect_wr(16'h0065, 8'hEE);
    expect_wr(16'h0064, 8'd144);
`endif
    expect_wr(16'h0066, 8'h11);
    run(150, -1);
    check("p2_we_count", we_count, 4);

    // LDI r3,7; SUB r3,r3; JZ 0x0030
    instr(16'h0000, 8'h0B, 8'h07, 8'h00);
    instr(16'h0003, 8'h33, 8'h03, 8'h00);
    instr(16'h0006, 8'h60, 8'h00, 8'h30);
    instr(16'h0009, 8'h1B, 8'h00, 8'h65);
    instr(16'h000C, 8'h78, 8'h00, 8'h00);
    instr(16'h0030, 8'h1B, 8'h00, 8'h64);
    instr(16'h0033, 8'h78, 8'h00, 8'h00);
    expect_wr(16'h0064, 8'h00);
    run(40, -1);
    check("jz_fetch_addr", trace[15], 16'h0030);

    // JNZ in place of JZ: falls through to pc+3.
    instr(16'h0006, 8'h68, 8'h00, 8'h30);
    expect_wr(16'h0065, 8'h00);
    run(40, -1);
    check("jnz_fetch_addr", trace[15], 16'h0009);

    // Fibonacci: 13 terms stored to address 100.
    instr(16'h0000, 8'h09, 8'h01, 8'h00);
    instr(16'h0003, 8'h0A, 8'h01, 8'h00);
    instr(16'h0006, 8'h0C, 8'd13, 8'h00);
    instr(16'h0009, 8'h0D, 8'h01, 8'h00);
    instr(16'h000C, 8'h19, 8'h00, 8'h64);
    instr(16'h000F, 8'h23, 8'h01, 8'h00);
    instr(16'h0012, 8'h2B, 8'h02, 8'h00);
    instr(16'h0015, 8'h21, 8'h02, 8'h00);
    instr(16'h0018, 8'h22, 8'h03, 8'h00);
    instr(16'h001B, 8'h34, 8'h05, 8'h00);
    instr(16'h001E, 8'h68, 8'h00, 8'h0C);
    instr(16'h0021, 8'h78, 8'h00, 8'h00);
    begin
      int fa, fb, ft;
      fa = 1;
      fb = 1;
      for (int i = 0; i < 13; i++) begin
        expect_wr(16'h0064, 8'(fa));
        ft = fa + fb;
        fa = fb;
        fb = ft;
      end
    end
    run(600, -1);
    check("fib_we_count", we_count, 13);
    check("fib_last", mem[100], 8'd233);

    // Store 0x5A at 0x1000, LD r4 back, store r4 to 100.
    instr(16'h0000, 8'h09, 8'h5A, 8'h00);
    instr(16'h0003, 8'h19, 8'h10, 8'h00);
    instr(16'h0006, 8'h14, 8'h10, 8'h00);
    instr(16'h0009, 8'h1C, 8'h00, 8'h64);
    instr(16'h000C, 8'h78, 8'h00, 8'h00);
    expect_wr(16'h1000, 8'h5A);
    expect_wr(16'h0064, 8'h5A);
    run(40, -1);
    check("ld_ex_addr", trace[14], 16'h1000);
    check("ld_next_f0", trace[16], 16'h0009);
    check("ld_st_cycle", we_last, 20);

    // Reset during F2 of the third instruction; program reruns from 0.
    instr(16'h0000, 8'h19, 8'h00, 8'h64);
    instr(16'h0003, 8'h09, 8'h05, 8'h00);
    instr(16'h0006, 8'h0A, 8'h09, 8'h00);
    instr(16'h0009, 8'h19, 8'h00, 8'h65);
    instr(16'h000C, 8'h78, 8'h00, 8'h00);
    expect_wr(16'h0064, 8'h00);
    expect_wr(16'h0064, 8'h00);
    expect_wr(16'h0065, 8'h05);
    run(60, 12);
    check("mid_rst_addr", trace[13], 16'h0000);
    check("mid_rst_we_count", we_count, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
